aes_add_round_key: RTL and testbench

AES AddRoundKey stage. It XORs a 128-bit state with a 128-bit round key and presents the result on a zero-latency combinational output. The same result is also captured in a one-deep registered pipeline stage with a valid/ready handshake. It sits between the key schedule and the SubBytes/ShiftRows/MixColumns datapath, and is used once per round (rounds 0..10).

---
 rtl/aes_add_round_key_if.sv | 36 +++
 rtl/aes_add_round_key.sv | 40 ++++
 tb/tb_aes_add_round_key.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/aes_add_round_key_if.sv
// AES AddRoundKey bus: state/key inputs, combinational sum,
// and a valid/ready handshake around the registered result.
interface aes_add_round_key_if #(
   parameter int DATA_W = 128
);
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] round_key;
   logic [DATA_W-1:0] sum;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] sum_q;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output data,
      output round_key,
      output in_valid,
      output out_ready,
      input  sum,
      input  in_ready,
      input  sum_q,
      input  out_valid
   );

   modport slave (
      input  data,
      input  round_key,
      input  in_valid,
      input  out_ready,
      output sum,
      output in_ready,
      output sum_q,
      output out_valid
   );
endinterface

// File: rtl/aes_add_round_key.sv
// AES AddRoundKey: state XOR round key, combinational plus a
// one-entry valid/ready pipeline register holding the same result.
module aes_add_round_key #(
   parameter int DATA_W = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   aes_add_round_key_if.slave   bus
);
   logic [DATA_W-1:0] w_sum;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_consume;
   logic [DATA_W-1:0] r_sum_q;
   logic              r_out_valid;

   assign w_sum      = bus.data ^ bus.round_key;
   assign w_in_ready = ~r_out_valid | bus.out_ready;
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_consume  = r_out_valid & bus.out_ready;

   assign bus.sum       = w_sum;
   assign bus.in_ready  = w_in_ready;
   assign bus.sum_q     = r_sum_q;
   assign bus.out_valid = r_out_valid;

   // Pipeline register: reset clears, accept loads (even when the
   // old entry drains the same cycle), a lone consume empties it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sum_q     <= '0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_sum_q     <= w_sum;
         r_out_valid <= 1'b1;
      end else if (w_consume) begin
         r_out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_aes_add_round_key.sv
// Directed and random checks of aes_add_round_key: combinational
// XOR, handshake timing, backpressure, reset and streaming order.
module tb_aes_add_round_key;
   localparam int W = 128;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   aes_add_round_key_if #(.DATA_W(W)) bus ();

   aes_add_round_key #(.DATA_W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [W-1:0] C1_D = 128'h00112233445566778899aabbccddeeff;
   localparam logic [W-1:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [W-1:0] C1_S = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [W-1:0] B_D  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [W-1:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [W-1:0] B_S  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [W-1:0] ONES = {W{1'b1}};

   logic [W-1:0] q[$];
   logic [W-1:0] exp_v;
   logic [W-1:0] rd, rk;
   logic         acc, con;
   int           n_acc, iter;

   initial begin
      reset         = 1'b1;
      bus.data      = '0;
      bus.round_key = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      step();
      step();
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_sum_q", bus.sum_q, '0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      reset = 1'b0;
      step();
      chk("post_rst_in_ready", bus.in_ready, 1'b1);

      // FIPS-197 C.1 round 0, combinational
      bus.data      = C1_D;
      bus.round_key = C1_K;
      #1;
      chk("c1_sum", bus.sum, C1_S);

      // Appendix B through the register
      bus.data      = B_D;
      bus.round_key = B_K;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("b_sum", bus.sum, B_S);
      step();
      bus.in_valid = 1'b0;
      chk("b_sum_q", bus.sum_q, B_S);
      chk("b_out_valid", bus.out_valid, 1'b1);
      step();
      chk("b_drained", bus.out_valid, 1'b0);
      chk("b_sum_q_hold", bus.sum_q, B_S);

      // Identity and corner cases
      bus.data      = B_D;
      bus.round_key = '0;
      #1;
      chk("key0", bus.sum, B_D);
      bus.round_key = B_D;
      #1;
      chk("d_eq_k", bus.sum, '0);
      bus.data      = ONES;
      bus.round_key = ONES;
      #1;
      chk("ones_ones", bus.sum, '0);
      bus.round_key = '0;
      #1;
      chk("ones_zero", bus.sum, ONES);
      bus.data = '0;
      for (int i = 0; i < W; i++) begin
         bus.round_key    = '0;
         bus.round_key[i] = 1'b1;
         exp_v            = '0;
         exp_v[i]         = 1'b1;
         #1;
         chk($sformatf("walk1_%0d", i), bus.sum, exp_v);
      end

      // Backpressure: A held while B waits three cycles
      step();
      bus.data      = C1_D;
      bus.round_key = C1_K;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      step();
      bus.data      = B_D;
      bus.round_key = B_K;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp_in_ready_%0d", c), bus.in_ready, 1'b0);
         chk($sformatf("bp_sum_q_%0d", c), bus.sum_q, C1_S);
         chk($sformatf("bp_valid_%0d", c), bus.out_valid, 1'b1);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", bus.in_ready, 1'b1);
      step();
      chk("bp_load_b", bus.sum_q, B_S);
      chk("bp_valid_b", bus.out_valid, 1'b1);

      // Reset mid-operation
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      step();
      chk("mr_pre_valid", bus.out_valid, 1'b1);
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.data      = C1_D;
      bus.round_key = C1_K;
      #1;
      chk("mr_sum_track", bus.sum, C1_S);
      step();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      chk("mr_out_valid", bus.out_valid, 1'b0);
      chk("mr_sum_q", bus.sum_q, '0);
      chk("mr_in_ready", bus.in_ready, 1'b1);
      chk("mr_sum_track2", bus.sum, C1_S);

      // Random streaming against a queue model
      n_acc = 0;
      iter  = 0;
      while (n_acc < 1000 && iter < 8000) begin
         iter++;
         rd = {$urandom, $urandom, $urandom, $urandom};
         rk = {$urandom, $urandom, $urandom, $urandom};
         bus.data      = rd;
         bus.round_key = rk;
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = $urandom_range(0, 1) == 1;
         #1;
         chk("rnd_sum", bus.sum, rd ^ rk);
         chk("rnd_valid", bus.out_valid, q.size() != 0);
         acc = bus.in_valid & bus.in_ready;
         con = bus.out_valid & bus.out_ready;
         if (con) begin
            if (q.size() == 0) begin
               chk("rnd_dup", 1'b1, 1'b0);
            end else begin
               chk("rnd_sum_q", bus.sum_q, q.pop_front());
            end
         end
         if (acc) begin
            q.push_back(rd ^ rk);
            n_acc++;
         end
         step();
      end
      chk("rnd_accept_count", n_acc, 1000);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4 && q.size() != 0; c++) begin
         #1;
         if (bus.out_valid) chk("drain_sum_q", bus.sum_q, q.pop_front());
         step();
      end
      chk("drain_empty", q.size(), 0);
      chk("drain_valid", bus.out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
